// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: MIPS memory opcodes, FSM states
// and the access size/sign decode used by the top and the lane aligner.
package load_store_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  typedef struct packed {
    logic  valid;
    logic  store;
    logic  sign;
    size_e size;
  } dec_t;

  function automatic dec_t decode_op(input logic [5:0] op);
    dec_t d;
    d.valid = 1'b1;
    d.store = 1'b0;
    d.sign  = 1'b0;
    d.size  = SZ_W;
    case (op)
      OP_LB:   begin d.size = SZ_B; d.sign = 1'b1; end
      OP_LH:   begin d.size = SZ_H; d.sign = 1'b1; end
      OP_LW:   d.size = SZ_W;
      OP_LBU:  d.size = SZ_B;
      OP_LHU:  d.size = SZ_H;
      OP_SB:   begin d.size = SZ_B; d.store = 1'b1; end
      OP_SH:   begin d.size = SZ_H; d.store = 1'b1; end
      OP_SW:   begin d.size = SZ_W; d.store = 1'b1; end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  // Halfwords need an even address, words a multiple of four; bytes never fault.
  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: extracts and extends the addressed lane of a
// read word for loads, and merges store data into a read word for sb/sh RMW.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  size_e       size_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane select: byte k lives in bits 8k+7:8k.
  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o   = rdata_i;
    merged_o = rdata_i;
    case (size_i)
      SZ_B: begin
        load_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
        merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_H: begin
        load_o = {{16{sign_i & half_sel[15]}}, half_sel};
        if (off_i[1]) merged_o[31:16] = wdata_i;
        else          merged_o[15:0]  = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one MEM-stage request at a time and runs whole-word
// read / write phases on the data memory, doing RMW for sb/sh.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request; checks opcode, alignment, range
// RD      | MemRead asserted, waiting for ack (load or sb/sh RMW read)
// WR      | MemWrite asserted, waiting for ack (sw or sb/sh RMW write)
// RESP    | one-cycle resp_valid pulse, then back to IDLE
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int MEM_WORDS   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [5:0]  mem_opcode,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ack
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e             state_q, state_d;
  logic               store_q, store_d;
  logic               sign_q, sign_d;
  size_e              size_q, size_d;
  logic [1:0]         off_q, off_d;
  logic [15:0]        wdata_lo_q, wdata_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [5:0]         opc_q, opc_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;

  dec_t               dec_in;
  logic               addr_bad;
  logic               timed_out;
  logic [31:0]        load_data;
  logic [31:0]        merged;

  assign dec_in    = decode_op(req_opcode);
  assign addr_bad  = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
  assign timed_out = cnt_q == CNT_W'(TIMEOUT_CYC - 1);

  lsu_lane_align u_align (
    .size_i   (size_q),
    .sign_i   (sign_q),
    .off_i    (off_q),
    .rdata_i  (mem_read_data),
    .wdata_i  (wdata_lo_q),
    .load_o   (load_data),
    .merged_o (merged)
  );

  // Next-state and registered-output decisions for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    sign_d     = sign_q;
    size_d     = size_q;
    off_d      = off_q;
    wdata_lo_d = wdata_lo_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    opc_d      = opc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d    = dec_in.store;
          sign_d     = dec_in.sign;
          size_d     = dec_in.size;
          off_d      = req_addr[1:0];
          wdata_lo_d = req_wdata[15:0];
          addr_d     = {2'b00, req_addr[31:2]};
          err_d      = 1'b0;
          rdata_d    = '0;
          cnt_d      = '0;
          if (!dec_in.valid || misaligned(dec_in.size, req_addr[1:0]) || addr_bad) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (dec_in.store && dec_in.size == SZ_W) begin
            wdata_d = req_wdata;
            wr_d    = 1'b1;
            opc_d   = OP_SW;
            state_d = ST_WR;
          end else begin
            rd_d    = 1'b1;
            opc_d   = OP_LW;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          rd_d  = 1'b0;
          cnt_d = '0;
          if (store_q) begin
            // sb/sh: the read word becomes the write word with one lane replaced
            wdata_d = merged;
            wr_d    = 1'b1;
            opc_d   = OP_SW;
            state_d = ST_WR;
          end else begin
            rdata_d = load_data;
            opc_d   = '0;
            state_d = ST_RESP;
          end
        end else if (timed_out) begin
          rd_d    = 1'b0;
          opc_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          wr_d    = 1'b0;
          opc_d   = '0;
          state_d = ST_RESP;
        end else if (timed_out) begin
          wr_d    = 1'b0;
          opc_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      store_q    <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= SZ_W;
      off_q      <= '0;
      wdata_lo_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      opc_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      sign_q     <= sign_d;
      size_q     <= size_d;
      off_q      <= off_d;
      wdata_lo_q <= wdata_lo_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      opc_q      <= opc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  assign req_ready      = state_q == ST_IDLE;
  assign resp_valid     = state_q == ST_RESP;
  assign resp_err       = resp_valid & err_q;
  assign resp_rdata     = resp_valid ? rdata_q : '0;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_opcode     = opc_q;
  assign mem_MemRead    = rd_q;
  assign mem_MemWrite   = wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table-driven single transactions against a
// behavioural word memory, plus wait-state, timeout and mid-transaction reset.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_opcode = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [5:0]  mem_opcode;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] mem_read_data = '0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYC(TO), .MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_opcode(mem_opcode),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_read_data(mem_read_data), .mem_ack(mem_ack)
  );

  logic [31:0] mem [0:255];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_delay = 0;
  bit ack_never = 1'b0;
  int wait_cnt = 0;
  int n_rd = 0, n_wr = 0, n_strb = 0, n_unstable = 0, n_resp = 0;
  bit prev_act = 1'b0;
  logic [31:0] prev_addr, prev_wd;
  logic [5:0]  prev_op;
  logic        strobe_at_resp = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Word memory: acks after ack_delay waiting cycles, garbage data otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      wait_cnt = 0;
      prev_act = 1'b0;
    end else if (mem_MemRead || mem_MemWrite) begin
      n_strb++;
      check("strobe_exclusive", {31'b0, mem_MemRead & mem_MemWrite}, 32'd0);
      check("mem_opcode", {26'b0, mem_opcode}, mem_MemWrite ? 32'h2b : 32'h23);
      if (prev_act && (mem_address !== prev_addr || mem_opcode !== prev_op ||
                       (mem_MemWrite && mem_write_data !== prev_wd)))
        n_unstable++;
      if (!ack_never && wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        wait_cnt = 0;
        prev_act = 1'b0;
        if (mem_MemWrite) begin
          mem[mem_address[7:0]] = mem_write_data;
          n_wr++;
        end else begin
          mem_read_data = mem[mem_address[7:0]];
          n_rd++;
        end
      end else begin
        mem_ack = 1'b0;
        mem_read_data = $urandom;
        wait_cnt++;
        prev_act = 1'b1;
        prev_addr = mem_address;
        prev_wd = mem_write_data;
        prev_op = mem_opcode;
      end
    end else begin
      mem_ack = 1'b0;
      mem_read_data = $urandom;
      wait_cnt = 0;
      prev_act = 1'b0;
    end
  end

  // Response monitor: pops the scoreboard on every resp_valid pulse.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      exp_t e;
      n_resp++;
      strobe_at_resp = mem_MemRead | mem_MemWrite;
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        check("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int guard;
    exp_t e;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_opcode = op;
    req_addr = addr;
    req_wdata = wd;
    e.rdata = exp_rdata;
    e.err = exp_err;
    e.lat = exp_lat;
    e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_opcode = '0;
    req_addr = '0;
    req_wdata = '0;
    check("req_ready_busy", {31'b0, req_ready}, 32'd0);
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      check("resp_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          pidx;
    logic [31:0] pval;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] cword;
  } vec_t;
  vec_t vecs[$];

  initial begin
    int r;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    vecs.push_back('{OP_LW,  32'h10, 32'h0, 4, 32'h8899AABB, 32'h8899AABB, 1'b0, 2, 1, 0, 32'h8899AABB});
    vecs.push_back('{OP_LB,  32'h13, 32'h0, 4, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h80FF1234});
    vecs.push_back('{OP_LBU, 32'h13, 32'h0, 4, 32'h80FF1234, 32'h00000080, 1'b0, 2, 1, 0, 32'h80FF1234});
    vecs.push_back('{OP_LHU, 32'h12, 32'h0, 4, 32'h80FF1234, 32'h000080FF, 1'b0, 2, 1, 0, 32'h80FF1234});
    vecs.push_back('{OP_LH,  32'h12, 32'h0, 4, 32'h80FF1234, 32'hFFFF80FF, 1'b0, 2, 1, 0, 32'h80FF1234});
    vecs.push_back('{OP_LB,  32'h10, 32'h0, 4, 32'h80FF1234, 32'h00000034, 1'b0, 2, 1, 0, 32'h80FF1234});
    vecs.push_back('{OP_LH,  32'h10, 32'h0, 4, 32'h80FF9234, 32'hFFFF9234, 1'b0, 2, 1, 0, 32'h80FF9234});
    vecs.push_back('{OP_SB,  32'h21, 32'h000000CD, 8, 32'h11223344, 32'h0, 1'b0, 3, 1, 1, 32'h1122CD44});
    vecs.push_back('{OP_SH,  32'h22, 32'hABCD5678, 8, 32'h11223344, 32'h0, 1'b0, 3, 1, 1, 32'h56783344});
    vecs.push_back('{OP_SB,  32'h23, 32'h000000EE, 8, 32'h11223344, 32'h0, 1'b0, 3, 1, 1, 32'hEE223344});
    vecs.push_back('{OP_SW,  32'h24, 32'hDEADBEEF, 9, 32'h0, 32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF});
    vecs.push_back('{OP_SH,  32'h05, 32'h0000FFFF, 1, 32'h55555555, 32'h0, 1'b1, 1, 0, 0, 32'h55555555});
    vecs.push_back('{6'h22,  32'h00, 32'h0, 0, 32'h12345678, 32'h0, 1'b1, 1, 0, 0, 32'h12345678});
    vecs.push_back('{OP_LW,  32'h02, 32'h0, 0, 32'h12345678, 32'h0, 1'b1, 1, 0, 0, 32'h12345678});
    vecs.push_back('{OP_LHU, 32'h07, 32'h0, 1, 32'h55555555, 32'h0, 1'b1, 1, 0, 0, 32'h55555555});
    vecs.push_back('{OP_LW,  32'h400, 32'h0, 0, 32'h12345678, 32'h0, 1'b1, 1, 0, 0, 32'h12345678});
    vecs.push_back('{OP_SW,  32'h80000000, 32'hFFFFFFFF, 0, 32'h12345678, 32'h0, 1'b1, 1, 0, 0, 32'h12345678});
    vecs.push_back('{OP_LW,  32'h3FC, 32'h0, 255, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 2, 1, 0, 32'hCAFEF00D});

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_strobes", {30'b0, mem_MemRead, mem_MemWrite}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    check("rst_mem_opcode", {26'b0, mem_opcode}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      mem[vecs[i].pidx] = vecs[i].pval;
      n_rd = 0;
      n_wr = 0;
      n_strb = 0;
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, vecs[i].lat);
      check("read_count", n_rd, vecs[i].nrd);
      check("write_count", n_wr, vecs[i].nwr);
      check("strobe_cycles", n_strb, vecs[i].nrd + vecs[i].nwr);
      check("mem_word", mem[vecs[i].pidx], vecs[i].cword);
    end

    // sw with three wait cycles: strobe and data held for four cycles
    ack_delay = 3;
    mem[10] = '0;
    n_wr = 0; n_strb = 0; n_unstable = 0;
    run_txn(OP_SW, 32'h28, 32'h0BADF00D, 32'h0, 1'b0, 5);
    check("wait_strobe_cycles", n_strb, 4);
    check("wait_stable", n_unstable, 0);
    check("wait_mem_word", mem[10], 32'h0BADF00D);
    check("wait_write_count", n_wr, 1);
    ack_delay = 0;

    // No ack: load times out, strobe dropped by the response cycle
    ack_never = 1'b1;
    n_rd = 0; n_strb = 0;
    run_txn(OP_LW, 32'h30, 32'h0, 32'h0, 1'b1, TO + 1);
    check("to_strobe_cycles", n_strb, TO);
    check("to_strobe_at_resp", {31'b0, strobe_at_resp}, 32'd0);
    check("to_read_count", n_rd, 0);

    // No ack on the RMW read: no write follows
    mem[12] = 32'hA5A5A5A5;
    n_wr = 0; n_strb = 0;
    run_txn(OP_SB, 32'h31, 32'h000000FF, 32'h0, 1'b1, TO + 1);
    check("to_rmw_strobe_cycles", n_strb, TO);
    check("to_rmw_write_count", n_wr, 0);
    check("to_rmw_mem_word", mem[12], 32'hA5A5A5A5);

    // Reset while waiting in RD: everything clears, no response afterwards
    @(negedge clk);
    req_valid = 1'b1;
    req_opcode = OP_LW;
    req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    req_opcode = '0;
    req_addr = '0;
    repeat (3) @(negedge clk);
    check("mid_rd_strobe", {31'b0, mem_MemRead}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {30'b0, mem_MemRead, mem_MemWrite}, 32'd0);
    check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("mid_rst_mem_address", mem_address, 32'd0);
    check("mid_rst_mem_opcode", {26'b0, mem_opcode}, 32'd0);
    r = n_resp;
    @(negedge clk);
    ack_never = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_rst_no_resp", n_resp, r);
    check("mid_rst_idle", {31'b0, req_ready}, 32'd1);

    // Recovery after reset
    mem[4] = 32'h13579BDF;
    run_txn(OP_LW, 32'h10, 32'h0, 32'h13579BDF, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store per handshake from the MEM stage and drives address, write data, opcode and MemRead/MemWrite toward the word-addressed data memory.
- Handles byte/halfword lanes: sign/zero extension on loads, read-modify-write for sb/sh, alignment checking and an ack timeout.
- Sits between the ALU result/rt register path and the data memory. Responds to the pipeline with a single-cycle resp_valid pulse.

Parameters:
- TIMEOUT_CYC, 16: maximum cycles a memory phase may wait for mem_ack before erroring.
- MEM_WORDS, 256: memory depth in words; word index >= MEM_WORDS is an error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  pipeline request present.
- req_ready  output  1  unit idle and able to accept.
- req_opcode  input  6  MIPS opcode: 0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu, 0x28 sb, 0x29 sh, 0x2b sw.
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  32  store data (rt).
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load result; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid: misaligned, bad opcode, out of range, or timeout.
- mem_address  output  32  word index = {2'b00, addr[31:2]}.
- mem_write_data  output  32  full word to write.
- mem_opcode  output  6  always 0x23 on reads and 0x2b on writes; the unit only issues whole-word accesses.
- mem_MemRead  output  1  read strobe.
- mem_MemWrite  output  1  write strobe.
- mem_read_data  input  32  memory read word.
- mem_ack  input  1  memory phase complete; read data valid in the same cycle.

Behaviour:
- Reset (async, rst_n=0): state IDLE, timeout counter 0.
  - req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
  - mem_MemRead=0; mem_MemWrite=0; mem_address=0; mem_write_data=0; mem_opcode=0.
  - Reset mid-transaction drops the transaction silently; no response is produced.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1. On req_valid, capture opcode, address and wdata.
  - Error check in priority order: unsupported opcode; misaligned access (lh/lhu/sh with addr[0]=1, lw/sw with addr[1:0]!=0); word index >= MEM_WORDS. Any error goes to RESP with err=1 and no memory access.
  - Otherwise loads, sb and sh go to RD; sw goes to WR.
- RD:
  - mem_MemRead=1, mem_address and mem_opcode held stable until mem_ack.
  - On mem_ack, register mem_read_data.
  - Loads then go to RESP.
  - sb/sh merge req_wdata's low byte/half into lane addr[1:0] of the read word (little-endian, byte k = bits 8k+7:8k), then go to WR.
- WR: mem_MemWrite=1 with mem_write_data held until mem_ack, then go to RESP.
- Timeout: counter clears on entering RD or WR and increments each cycle without mem_ack. On reaching TIMEOUT_CYC-1 without ack, deassert strobes and go to RESP with err=1. A failed sb/sh RMW read performs no write.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, then return to IDLE.
- Load extension: lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word unchanged.
- Strobes: MemRead and MemWrite are never both high. Strobes are registered outputs.
- Latency with zero-wait memory (ack in the first strobe cycle), counting the accept cycle as cycle 0:
  - loads and sw: resp_valid in cycle 2.
  - sb/sh: resp_valid in cycle 3.
- Throughput: one transaction in flight. req_ready is low from the cycle after accept until IDLE is re-entered.
- A mem_ack arriving in IDLE or RESP is ignored.

Decomposition:
- Shared package holds:
  - opcode constants (OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW);
  - the state enum;
  - the size/sign decode typedef.
- One natural sub-module, lsu_lane_align, is purely combinational:
  - load-side byte/half extract with extension;
  - store-side lane merge.

Test Plan:
- lw addr=0x10, mem word 4 = 0x8899AABB, ack immediate -> mem_address=4, resp_rdata=0x8899AABB, resp_err=0, resp_valid in cycle 2.
- lb addr=0x13, word=0x80FF1234 -> resp_rdata=0xFFFFFF80; lbu same address -> 0x00000080; lhu addr=0x12 -> 0x000080FF.
- sb addr=0x21, wdata=0x000000CD, memory word 8=0x11223344 -> one read of word 8 then a write of 0x1122CD44, resp_valid in cycle 3.
- sh addr=0x05 -> resp_err=1 with no MemRead/MemWrite asserted; opcode 0x22 -> resp_err=1.
- sw with mem_ack held low for 3 cycles -> strobe and data stable 4 cycles, resp_valid next cycle. With ack never asserted -> resp_err=1 after TIMEOUT_CYC cycles and strobe deasserted.
- rst_n pulled low during the RD wait -> all outputs 0 immediately, req_ready=1, and no resp_valid after release.
